sphere_stream_gen: RTL
======================

// Module: sphere_stream_gen
// PURPOSE
//  Streaming generator of low-discrepancy points on the unit 2-sphere, with one point per index k.
//  One command carries a start index, base pair and point count; the block then emits COUNT consecutive points.
//  Each point is computed as:
//    v0 = vdc(k, b0)          v1 = vdc(k, b1)
//    z = 2*v0 - 1             s = sqrt(1 - z^2)
//    x = s*cos(2*pi*v1)       y = s*sin(2*pi*v1)
//  It is the parametrised, back-pressured successor of the single-shot 32-bit sphere FSM.
//  It sits between the sequence controller and the point-cloud buffer.
// PARAMETERS
//  WIDTH        32  output word width; signed two's complement
//  FRAC         16  fractional bits of the fixed-point format; ONE = 1<<FRAC
//  KW           32  index width
//  CNT_W        16  point-count width
//  CORDIC_ITERS 16  CORDIC micro-rotations; must be <= FRAC
// PORTS
//  clk        in   1      clock; all logic on the rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      command valid
//  in_ready   out  1      command accepted when in_valid & in_ready
//  k_in       in   KW     first index
//  base_sel0  in   2      z base: 0:2, 1:3, 2:5, 3:7
//  base_sel1  in   2      theta base, same encoding
//  count_in   in   CNT_W  number of points; 0 is treated as 1
//  out_valid  out  1      point valid
//  out_ready  in   1      downstream accepts the point
//  result_x   out  WIDTH  x, Q(WIDTH-FRAC).FRAC
//  result_y   out  WIDTH  y, same format
//  result_z   out  WIDTH  z, same format
//  out_k      out  KW     index of the emitted point
//  out_last   out  1      high on the final point of the command
// BEHAVIOUR
//  Reset:
//  - state=IDLE, in_ready=1, out_valid=0, out_last=0.
//  - result_x/y/z=0 and out_k=0.
//  - Reset asserted in any state aborts the command in the same edge; the partial point is discarded.
//  IDLE: in_ready=1 only here.
//  - Acceptance latches k, both bases and count (0 becomes 1), then goes to VDC.
//  VDC: both van der Corput values are produced in parallel, one digit per cycle each.
//  - Per cycle: d = q mod b; q = q / b; v += d*sc; sc = sc / b.
//  - sc starts at ONE/b. All divides are truncating unsigned divides.
//  - A channel stops when q==0 or sc==0. Leave VDC when both channels are done.
//  - This takes at most KW cycles.
//  - k==0 gives v0=v1=0, which yields z=-ONE and x=y=0 exactly.
//  ZSQ, 1 cycle:
//  - z = (v0<<1) - ONE.
//  - r = ONE - ((z*z) >>> FRAC); the product is 2*WIDTH wide.
//  - r is clamped to >= 0.
//  SQRT: restoring bit-serial square root of r<<FRAC, one result bit per cycle, giving s.
//  CORDIC: rotation mode, CORDIC_ITERS cycles. Angle is in turn units (v1 is already a turn fraction).
//  - The top 2 fraction bits of v1 select the quadrant; the remainder is rotated.
//  - The atan table is a localparam in turns.
//  - Start vector is (s*Kinv, 0), with Kinv = round(0.607253*ONE). No post-multiply.
//  - The quadrant fold is applied on exit: swap and/or negate.
//  - Arithmetic right shifts; no saturation is needed since |x|,|y| <= ONE.
//  OUT: out_valid=1; result_*, out_k and out_last are registered and held stable until out_ready.
//  - out_last = (remaining == 1).
//  - On the handshake: if last, go to IDLE, otherwise k = k+1 (wraps modulo 2^KW) and go to VDC.
//  - out_valid falls the cycle after the handshake; there is no bubble-free back-to-back output.
//  Latency per point: VDC digits + 1 + FRAC + CORDIC_ITERS + 1 cycles.
//  - At defaults this is at most 66 cycles.
//  - The output stalls only in OUT; upstream is stalled for the entire command.
//  Only one command is in flight; in_valid during busy is ignored (no ready, no capture).
// CONFIGURATION
//  SPHERE_CYCLE_CNT_EN defined: adds port "cyc_cnt out 16".
//  - cyc_cnt gives the cycles from VDC entry to OUT entry for the currently presented point.
//  - It is held with the point and reset to 0.
//  SPHERE_CYCLE_CNT_EN undefined:
//  - The port and counter are absent.
//  - All other behaviour is identical.
// TESTING
//  Tolerance is +/-64 LSB at FRAC=16.
//  1. Reset, then check all outputs:
//     - out_valid=0, in_ready=1, result_*=0.
//  2. k=1, bases[2,3], count=1:
//     - x=FFFF8000, y=0000DDB3, z=00000000.
//     - out_last=1, out_k=1.
//  3. k=2, bases[2,3], count=3:
//     - 3 points are emitted; out_last only on the 3rd.
//     - Point 1 (k=2): x=FFFF9126, y=FFFF4000, z=FFFF8000.
//     - Every point satisfies x^2+y^2+z^2 = ONE +/- 256 LSB.
//  4. k=0, count=0:
//     - Exactly one point: x=0, y=0, z=FFFF0000.
//     - out_last=1.
//  5. Hold out_ready=0 for 20 cycles during test 3:
//     - Outputs stay stable and in_ready stays 0.
//     - Release out_ready: the next point follows.
//  6. Wrap and reset abort:
//     - k=FFFFFFFF, count=2: out_k sequence is FFFFFFFF then 00000000.
//     - Assert rst in CORDIC: IDLE next cycle, no point emitted.

Source files
------------

// File: rtl/sphere_stream_gen.sv
// sphere_stream_gen: streams low-discrepancy unit-sphere points (van der Corput -> z/sqrt -> CORDIC).
// Optional per-point cycle counter port is enabled by defining SPHERE_CYCLE_CNT_EN.
module sphere_stream_gen #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned FRAC         = 16,
   parameter int unsigned KW           = 32,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned CORDIC_ITERS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [KW-1:0]    k_in,
   input  logic [1:0]       base_sel0,
   input  logic [1:0]       base_sel1,
   input  logic [CNT_W-1:0] count_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result_x,
   output logic [WIDTH-1:0] result_y,
   output logic [WIDTH-1:0] result_z,
   output logic [KW-1:0]    out_k,
   output logic             out_last
`ifdef SPHERE_CYCLE_CNT_EN
   ,
   output logic [15:0]      cyc_cnt
`endif
);

   localparam int unsigned W2   = 2 * WIDTH;
   localparam int unsigned SW2  = 2 * FRAC;
   localparam int unsigned SQ_W = FRAC + 4;
   localparam int unsigned IT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1) << FRAC;
   localparam logic [WIDTH-1:0] AMASK = (ONE >> 2) - WIDTH'(1);
   localparam logic [WIDTH-1:0] KINV  =
      WIDTH'((64'd607253 * (64'd1 << FRAC) + 64'd500000) / 64'd1000000);
   // atan(2^-i) in turns at 2^-16 resolution, rescaled to FRAC on use
   localparam logic [15:0] ATAN16 [16] = '{
      16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
      16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
   };

   typedef enum logic [2:0] {IDLE, VDC, ZSQ, SQRT, CORDIC, OUT} state_t;

   function automatic logic [WIDTH-1:0] atan_turn(input logic [IT_W-1:0] i);
      logic [63:0] t;
      t = (i < IT_W'(16)) ? 64'(ATAN16[i[3:0]]) : 64'd0;
      atan_turn = WIDTH'((t << FRAC) >> 16);
   endfunction

   function automatic logic [KW-1:0] div_k(input logic [KW-1:0] a, input logic [1:0] sel);
      case (sel)
         2'd0:    div_k = a / KW'(2);
         2'd1:    div_k = a / KW'(3);
         2'd2:    div_k = a / KW'(5);
         default: div_k = a / KW'(7);
      endcase
   endfunction

   function automatic logic [2:0] mod_k(input logic [KW-1:0] a, input logic [1:0] sel);
      case (sel)
         2'd0:    mod_k = 3'(a % KW'(2));
         2'd1:    mod_k = 3'(a % KW'(3));
         2'd2:    mod_k = 3'(a % KW'(5));
         default: mod_k = 3'(a % KW'(7));
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] div_w(input logic [WIDTH-1:0] a, input logic [1:0] sel);
      case (sel)
         2'd0:    div_w = a / WIDTH'(2);
         2'd1:    div_w = a / WIDTH'(3);
         2'd2:    div_w = a / WIDTH'(5);
         default: div_w = a / WIDTH'(7);
      endcase
   endfunction

   state_t                   state_q, state_d;
   logic [KW-1:0]            k_q, k_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [1:0]               sel_q [2];
   logic [1:0]               sel_d [2];
   logic [KW-1:0]            q_q [2];
   logic [KW-1:0]            q_d [2];
   logic [WIDTH-1:0]         v_q [2];
   logic [WIDTH-1:0]         v_d [2];
   logic [WIDTH-1:0]         sc_q [2];
   logic [WIDTH-1:0]         sc_d [2];
   logic signed [WIDTH-1:0]  z_q, z_d;
   logic [SW2-1:0]           rad_q, rad_d;
   logic [SQ_W-1:0]          rem_q, rem_d;
   logic [FRAC-1:0]          root_q, root_d;
   logic                     s_one_q, s_one_d;
   logic [IT_W-1:0]          it_q, it_d;
   logic [1:0]               quad_q, quad_d;
   logic signed [WIDTH-1:0]  cx_q, cx_d, cy_q, cy_d, ca_q, ca_d;
   logic [WIDTH-1:0]         rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
   logic [KW-1:0]            ok_q, ok_d;
   logic                     last_q, last_d;

   logic [1:0]               ch_done;
   logic                     load_vdc;
   logic signed [WIDTH-1:0]  zt, xs, ys;
   logic signed [W2-1:0]     zz;
   logic [WIDTH-1:0]         sq, r_val, s_val;
   logic [SQ_W-1:0]          rem_n, trial;
   logic [FRAC-1:0]          root_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         cnt_q   <= '0;
         sel_q   <= '{default: '0};
         q_q     <= '{default: '0};
         v_q     <= '{default: '0};
         sc_q    <= '{default: '0};
         z_q     <= '0;
         rad_q   <= '0;
         rem_q   <= '0;
         root_q  <= '0;
         s_one_q <= 1'b0;
         it_q    <= '0;
         quad_q  <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
         ca_q    <= '0;
         rx_q    <= '0;
         ry_q    <= '0;
         rz_q    <= '0;
         ok_q    <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         q_q     <= q_d;
         v_q     <= v_d;
         sc_q    <= sc_d;
         z_q     <= z_d;
         rad_q   <= rad_d;
         rem_q   <= rem_d;
         root_q  <= root_d;
         s_one_q <= s_one_d;
         it_q    <= it_d;
         quad_q  <= quad_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         ca_q    <= ca_d;
         rx_q    <= rx_d;
         ry_q    <= ry_d;
         rz_q    <= rz_d;
         ok_q    <= ok_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      q_d      = q_q;
      v_d      = v_q;
      sc_d     = sc_q;
      z_d      = z_q;
      rad_d    = rad_q;
      rem_d    = rem_q;
      root_d   = root_q;
      s_one_d  = s_one_q;
      it_d     = it_q;
      quad_d   = quad_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      ca_d     = ca_q;
      rx_d     = rx_q;
      ry_d     = ry_q;
      rz_d     = rz_q;
      ok_d     = ok_q;
      last_d   = last_q;
      ch_done  = '0;
      load_vdc = 1'b0;
      zt       = '0;
      zz       = '0;
      sq       = '0;
      r_val    = '0;
      s_val    = '0;
      xs       = '0;
      ys       = '0;
      rem_n    = '0;
      trial    = '0;
      root_n   = '0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               k_d      = k_in;
               cnt_d    = (count_in == '0) ? CNT_W'(1) : count_in;
               sel_d[0] = base_sel0;
               sel_d[1] = base_sel1;
               load_vdc = 1'b1;
               state_d  = VDC;
            end
         end
         VDC: begin
            for (int unsigned c = 0; c < 2; c++) begin
               if (q_q[1'(c)] != '0 && sc_q[1'(c)] != '0) begin
                  q_d[1'(c)]  = div_k(q_q[1'(c)], sel_q[1'(c)]);
                  v_d[1'(c)]  = v_q[1'(c)] + WIDTH'(mod_k(q_q[1'(c)], sel_q[1'(c)])) * sc_q[1'(c)];
                  sc_d[1'(c)] = div_w(sc_q[1'(c)], sel_q[1'(c)]);
               end
               ch_done[1'(c)] = (q_d[1'(c)] == '0) || (sc_d[1'(c)] == '0);
            end
            if (&ch_done) state_d = ZSQ;
         end
         ZSQ: begin
            zt    = signed'((v_q[0] << 1) - ONE);
            zz    = W2'(zt) * W2'(zt);
            sq    = WIDTH'(zz >>> FRAC);
            r_val = (sq > ONE) ? '0 : ONE - sq;
            z_d   = zt;
            // r == ONE needs a FRAC+1 bit root; flag it and substitute ONE on exit
            s_one_d = (r_val >= ONE);
            rad_d   = (r_val >= ONE) ? '1 : (SW2'(r_val) << FRAC);
            rem_d   = '0;
            root_d  = '0;
            it_d    = '0;
            state_d = SQRT;
         end
         SQRT: begin
            rem_n = (rem_q << 2) | SQ_W'(rad_q[SW2-1 -: 2]);
            trial = SQ_W'({root_q, 2'b01});
            if (rem_n >= trial) begin
               rem_d  = rem_n - trial;
               root_n = {root_q[FRAC-2:0], 1'b1};
            end else begin
               rem_d  = rem_n;
               root_n = {root_q[FRAC-2:0], 1'b0};
            end
            root_d = root_n;
            rad_d  = rad_q << 2;
            it_d   = it_q + IT_W'(1);
            if (it_q == IT_W'(FRAC - 1)) begin
               s_val   = s_one_q ? ONE : WIDTH'(root_n);
               cx_d    = signed'(WIDTH'((W2'(s_val) * W2'(KINV)) >> FRAC));
               cy_d    = '0;
               ca_d    = signed'(v_q[1] & AMASK);
               quad_d  = v_q[1][FRAC-1:FRAC-2];
               it_d    = '0;
               state_d = CORDIC;
            end
         end
         CORDIC: begin
            xs = cx_q >>> it_q;
            ys = cy_q >>> it_q;
            if (!ca_q[WIDTH-1]) begin
               cx_d = cx_q - ys;
               cy_d = cy_q + xs;
               ca_d = ca_q - signed'(atan_turn(it_q));
            end else begin
               cx_d = cx_q + ys;
               cy_d = cy_q - xs;
               ca_d = ca_q + signed'(atan_turn(it_q));
            end
            it_d = it_q + IT_W'(1);
            if (it_q == IT_W'(CORDIC_ITERS - 1)) begin
               case (quad_q)
                  2'd0:    begin rx_d = cx_d;  ry_d = cy_d;  end
                  2'd1:    begin rx_d = -cy_d; ry_d = cx_d;  end
                  2'd2:    begin rx_d = -cx_d; ry_d = -cy_d; end
                  default: begin rx_d = cy_d;  ry_d = -cx_d; end
               endcase
               rz_d    = z_q;
               ok_d    = k_q;
               last_d  = (cnt_q == CNT_W'(1));
               state_d = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               if (last_q) begin
                  state_d = IDLE;
               end else begin
                  k_d      = k_q + KW'(1);
                  cnt_d    = cnt_q - CNT_W'(1);
                  load_vdc = 1'b1;
                  state_d  = VDC;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load_vdc) begin
         for (int unsigned c = 0; c < 2; c++) begin
            q_d[1'(c)]  = k_d;
            v_d[1'(c)]  = '0;
            sc_d[1'(c)] = div_w(ONE, sel_d[1'(c)]);
         end
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == OUT);
   assign result_x  = rx_q;
   assign result_y  = ry_q;
   assign result_z  = rz_q;
   assign out_k     = ok_q;
   assign out_last  = last_q;

`ifdef SPHERE_CYCLE_CNT_EN
   logic [15:0] run_q, run_d, cyc_q, cyc_d;

   always_comb begin
      run_d = '0;
      cyc_d = cyc_q;
      if (state_q inside {VDC, ZSQ, SQRT, CORDIC}) run_d = run_q + 16'd1;
      if (state_q == CORDIC && state_d == OUT) cyc_d = run_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q <= '0;
         cyc_q <= '0;
      end else begin
         run_q <= run_d;
         cyc_q <= cyc_d;
      end
   end

   assign cyc_cnt = cyc_q;
`endif

endmodule
